// File: rtl/input_conditioner_if.sv
// Raw board inputs and their conditioned counterparts for input_conditioner.
// master = board/stimulus side, slave = conditioner side.
interface input_conditioner_if #(
    parameter int unsigned SW_WIDTH = 16
);
    logic                run_btn_i;
    logic                continue_btn_i;
    logic [SW_WIDTH-1:0] sw_raw_i;
    logic                run_o;
    logic                run_pulse_o;
    logic                continue_o;
    logic                continue_pulse_o;
    logic [SW_WIDTH-1:0] sw_o;

    modport master (
        output run_btn_i,
        output continue_btn_i,
        output sw_raw_i,
        input  run_o,
        input  run_pulse_o,
        input  continue_o,
        input  continue_pulse_o,
        input  sw_o
    );

    modport slave (
        input  run_btn_i,
        input  continue_btn_i,
        input  sw_raw_i,
        output run_o,
        output run_pulse_o,
        output continue_o,
        output continue_pulse_o,
        output sw_o
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces run/continue buttons and the switch bank, with rising-edge pulses.
// Define INPUT_COND_DEBOUNCE_BYPASS_EN to drop the counters (outputs follow the synchronizers).
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned SW_WIDTH        = 16
) (
    input logic                clk,
    input logic                reset,
    input_conditioner_if.slave io
);
    // Bit 0 = run, bit 1 = continue.
    logic [1:0]          btn_raw;
    logic [1:0]          btn_s1;
    logic [1:0]          btn_s2;
    logic [1:0]          btn_stable;
    logic [1:0]          btn_pulse;
    logic [1:0]          btn_commit;
    logic [SW_WIDTH-1:0] sw_s1;
    logic [SW_WIDTH-1:0] sw_s2;
    logic [SW_WIDTH-1:0] sw_q;

    assign btn_raw = {io.continue_btn_i, io.run_btn_i};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= io.sw_raw_i;
            sw_s2  <= sw_s1;
        end
    end

`ifndef INPUT_COND_DEBOUNCE_BYPASS_EN
    localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
            end else if (btn_s2[g] == btn_stable[g]) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign btn_commit[g] = (btn_s2[g] != btn_stable[g]) && (cnt == CNT_LAST);
    end

    logic [SW_WIDTH-1:0] sw_last;
    logic [CNT_W-1:0]    sw_cnt;

    // Any bit change restarts qualification; sw_q only ever loads a full qualified vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_last <= '0;
            sw_cnt  <= '0;
            sw_q    <= '0;
        end else begin
            sw_last <= sw_s2;
            if (sw_s2 != sw_last) begin
                sw_cnt <= '0;
            end else if (sw_s2 != sw_q) begin
                if (sw_cnt == CNT_LAST) begin
                    sw_q   <= sw_s2;
                    sw_cnt <= '0;
                end else begin
                    sw_cnt <= sw_cnt + CNT_W'(1);
                end
            end else begin
                sw_cnt <= '0;
            end
        end
    end
`else
    assign btn_commit = btn_s2 ^ btn_stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_q <= '0;
        end else begin
            sw_q <= sw_s2;
        end
    end
`endif

    // Pulse registers alongside stable, so it reads 1 in the first cycle stable does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_stable <= '0;
            btn_pulse  <= '0;
        end else begin
            btn_stable <= (btn_stable & ~btn_commit) | (btn_s2 & btn_commit);
            btn_pulse  <= btn_commit & btn_s2 & ~btn_stable;
        end
    end

    assign io.run_o            = btn_stable[0];
    assign io.run_pulse_o      = btn_pulse[0];
    assign io.continue_o       = btn_stable[1];
    assign io.continue_pulse_o = btn_pulse[1];
    assign io.sw_o             = sw_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Build with INPUT_COND_DEBOUNCE_BYPASS_EN defined to run the bypass case instead.
module tb_input_conditioner;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    input_conditioner_if #(.SW_WIDTH(16)) bus ();

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SW_WIDTH       (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Advance one clock edge, then settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".run"},    {31'd0, bus.run_o},            32'd0);
        check({tag, ".runp"},   {31'd0, bus.run_pulse_o},      32'd0);
        check({tag, ".cont"},   {31'd0, bus.continue_o},       32'd0);
        check({tag, ".contp"},  {31'd0, bus.continue_pulse_o}, 32'd0);
        check({tag, ".sw"},     {16'd0, bus.sw_o},             32'd0);
    endtask

    initial begin
        n_tests            = 0;
        n_fail             = 0;
        reset              = 1'b1;
        bus.run_btn_i      = 1'b0;
        bus.continue_btn_i = 1'b0;
        bus.sw_raw_i       = 16'h0000;
        #1;

`ifndef INPUT_COND_DEBOUNCE_BYPASS_EN
        // Reset held with inputs toggling: everything stays 0.
        for (int unsigned k = 0; k < 5; k++) begin
            bus.run_btn_i      = k[0];
            bus.continue_btn_i = ~k[0];
            bus.sw_raw_i       = k[0] ? 16'hFFFF : 16'h5A5A;
            step();
            check_all_zero("rst_hold");
        end
        // Deassert with run held and switches set: run at E6, switches at E7.
        bus.run_btn_i      = 1'b1;
        bus.continue_btn_i = 1'b0;
        bus.sw_raw_i       = 16'h1234;
        reset              = 1'b0;
        for (int unsigned k = 1; k <= 7; k++) begin
            step();
            check("rst_rel.run",  {31'd0, bus.run_o},       (k >= 6) ? 32'd1 : 32'd0);
            check("rst_rel.runp", {31'd0, bus.run_pulse_o}, (k == 6) ? 32'd1 : 32'd0);
            check("rst_rel.sw",   {16'd0, bus.sw_o},        (k >= 7) ? 32'h1234 : 32'h0);
        end
        bus.run_btn_i = 1'b0;
        bus.sw_raw_i  = 16'h0000;
        settle(12);
        check("idle.run", {31'd0, bus.run_o}, 32'd0);
        check("idle.sw",  {16'd0, bus.sw_o},  32'd0);

        // Clean press, held 20 cycles, then release.
        bus.run_btn_i = 1'b1;
        for (int unsigned k = 1; k <= 20; k++) begin
            step();
            check("press.run",  {31'd0, bus.run_o},       (k >= 6) ? 32'd1 : 32'd0);
            check("press.runp", {31'd0, bus.run_pulse_o}, (k == 6) ? 32'd1 : 32'd0);
        end
        bus.run_btn_i = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            step();
            check("release.run",  {31'd0, bus.run_o},       (k >= 6) ? 32'd0 : 32'd1);
            check("release.runp", {31'd0, bus.run_pulse_o}, 32'd0);
        end

        // Bounce: 3 high, 2 low, 3 high, low. Never qualifies.
        for (int unsigned k = 1; k <= 16; k++) begin
            bus.continue_btn_i = (k <= 3) || (k >= 6 && k <= 8);
            step();
            check("bounce.cont",  {31'd0, bus.continue_o},       32'd0);
            check("bounce.contp", {31'd0, bus.continue_pulse_o}, 32'd0);
        end

        // Switch update to 0x00A3.
        bus.sw_raw_i = 16'h00A3;
        for (int unsigned k = 1; k <= 8; k++) begin
            step();
            check("sw1", {16'd0, bus.sw_o}, (k >= 7) ? 32'h00A3 : 32'h0000);
        end
        // Change to 0x0055, then 0x0007 two edges later: only 0x0007 may appear.
        bus.sw_raw_i = 16'h0055;
        for (int unsigned k = 1; k <= 10; k++) begin
            if (k == 3) bus.sw_raw_i = 16'h0007;
            step();
            check("sw2", {16'd0, bus.sw_o}, (k >= 9) ? 32'h0007 : 32'h00A3);
        end

        // Simultaneous presses on the same edge.
        bus.run_btn_i      = 1'b1;
        bus.continue_btn_i = 1'b1;
        for (int unsigned k = 1; k <= 8; k++) begin
            step();
            check("simul.runp",  {31'd0, bus.run_pulse_o},      (k == 6) ? 32'd1 : 32'd0);
            check("simul.contp", {31'd0, bus.continue_pulse_o}, (k == 6) ? 32'd1 : 32'd0);
            check("simul.cont",  {31'd0, bus.continue_o},       (k >= 6) ? 32'd1 : 32'd0);
        end
        bus.run_btn_i      = 1'b0;
        bus.continue_btn_i = 1'b0;
        settle(10);

        // Reset mid-qualification, button kept held through and after reset.
        bus.run_btn_i = 1'b1;
        settle(3);
        reset = 1'b1;
        #1;
        check("midrst.async", {31'd0, bus.run_o}, 32'd0);
        for (int unsigned k = 1; k <= 3; k++) begin
            step();
            check("midrst.run",  {31'd0, bus.run_o},       32'd0);
            check("midrst.runp", {31'd0, bus.run_pulse_o}, 32'd0);
        end
        reset = 1'b0;
        begin
            int unsigned pulses;
            pulses = 0;
            for (int unsigned k = 1; k <= 10; k++) begin
                step();
                if (bus.run_pulse_o) pulses++;
                check("midrst.rel.runp", {31'd0, bus.run_pulse_o}, (k == 6) ? 32'd1 : 32'd0);
                check("midrst.rel.run",  {31'd0, bus.run_o},       (k >= 6) ? 32'd1 : 32'd0);
            end
            check("midrst.npulse", pulses, 32'd1);
        end
        bus.run_btn_i = 1'b0;
        settle(8);
`else
        settle(2);
        reset = 1'b0;
        check_all_zero("byp_rst");
        // One-cycle raw pulse passes straight through after 3 edges.
        bus.run_btn_i = 1'b1;
        for (int unsigned k = 1; k <= 6; k++) begin
            step();
            if (k == 1) bus.run_btn_i = 1'b0;
            check("byp.run",  {31'd0, bus.run_o},       (k == 3) ? 32'd1 : 32'd0);
            check("byp.runp", {31'd0, bus.run_pulse_o}, (k == 3) ? 32'd1 : 32'd0);
        end
        bus.sw_raw_i = 16'hBEEF;
        for (int unsigned k = 1; k <= 4; k++) begin
            step();
            check("byp.sw", {16'd0, bus.sw_o}, (k >= 3) ? 32'hBEEF : 32'h0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
